data_bank_arbiter: RTL and testbench

- Sits in front of the data-bank array of the L1 data cache. The array is LINE_WORDS data banks, one per word offset, each SETS x WAYS x DATA_W.
- Shares the single bank write port between CPU store hits and the memory refill sequencer.
- Gates the shared read port against refill and write hazards.
- Sequences multi-beat refills into the victim way and reports completion to the miss handler.

---
 rtl/data_bank_arbiter.sv | 174 +++++++++++++++++
 tb/tb_data_bank_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bank_arbiter.sv
// ---------------------------------------------------------------------------
// data_bank_arbiter
//
// Front end of the L1 data-cache data-bank array (LINE_WORDS word banks, each
// SETS x WAYS x DATA_W). Shares the single bank write port between CPU store
// hits and the refill sequencer, sequences multi-beat refills into the victim
// way, and gates the shared read port against refill and write hazards.
//
// Ports
//   clock, reset            system clock; asynchronous active-low reset
//   st_*                    store-hit write request (valid/ready, set, way,
//                           word offset, data); written with zero latency
//   rf_start/_ready         refill request handshake; rf_set/rf_way are
//                           captured when the request is accepted
//   rf_beat_*               refill data beats, offsets 0..LINE_WORDS-1 in order
//   rf_done                 one-cycle pulse after the last beat is written
//   rd_valid/_ready, rd_set lookup read request to the banks
//   rd_resp_valid           bank data valid, one cycle after an issued read
//   bk_w_*                  bank write port (enable, set, way, offset, data)
//   bk_r_set                bank read set, shared by all word banks
// ---------------------------------------------------------------------------
module data_bank_arbiter #(
    parameter  int SET_W      = 7,
    parameter  int WAYS       = 8,
    parameter  int DATA_W     = 32,
    parameter  int LINE_WORDS = 4,
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              st_valid,
    output logic              st_ready,
    input  logic [SET_W-1:0]  st_set,
    input  logic [WAYS-1:0]   st_way,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [DATA_W-1:0] st_data,

    input  logic              rf_start,
    output logic              rf_start_ready,
    input  logic [SET_W-1:0]  rf_set,
    input  logic [WAYS-1:0]   rf_way,
    input  logic              rf_beat_valid,
    output logic              rf_beat_ready,
    input  logic [DATA_W-1:0] rf_beat_data,
    output logic              rf_done,

    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [SET_W-1:0]  rd_set,
    output logic              rd_resp_valid,

    output logic              bk_w_en,
    output logic [SET_W-1:0]  bk_w_set,
    output logic [WAYS-1:0]   bk_w_way,
    output logic [OFF_W-1:0]  bk_w_off,
    output logic [DATA_W-1:0] bk_w_data,
    output logic [SET_W-1:0]  bk_r_set
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } arbState;

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

    arbState            stateQ, stateD;
    logic [OFF_W-1:0]   cntQ, cntD;
    logic               rrLastQ, rrLastD;     // 1: refill wins the next tie
    logic [SET_W-1:0]   rfSetQ;
    logic [WAYS-1:0]    rfWayQ;
    logic               latchRefill;
    logic               rdRespQ;
    logic               rdHazard;

    // Next-state and write-port control. Grants are also gated by reset so
    // every handshake output is low while reset is asserted, not only after
    // the first clock edge.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        stateD         = stateQ;
        cntD           = cntQ;
        rrLastD        = rrLastQ;
        latchRefill    = 1'b0;
        st_ready       = 1'b0;
        rf_start_ready = 1'b0;
        rf_beat_ready  = 1'b0;
        rf_done        = 1'b0;
        bk_w_en        = 1'b0;
        bk_w_set       = '0;
        bk_w_way       = '0;
        bk_w_off       = '0;
        bk_w_data      = '0;

        if (reset) begin
            unique case (stateQ)
                IDLE: begin
                    // The round-robin pointer only moves when both requesters
                    // compete; an uncontested grant leaves it alone.
                    if (st_valid && (!rf_start || !rrLastQ)) begin
                        st_ready  = 1'b1;
                        bk_w_en   = 1'b1;
                        bk_w_set  = st_set;
                        bk_w_way  = st_way;
                        bk_w_off  = st_off;
                        bk_w_data = st_data;
                        if (rf_start) rrLastD = 1'b1;
                    end else if (rf_start) begin
                        rf_start_ready = 1'b1;
                        latchRefill    = 1'b1;
                        cntD           = '0;
                        stateD         = REFILL;
                        if (st_valid) rrLastD = 1'b0;
                    end
                end
                REFILL: begin
                    rf_beat_ready = 1'b1;
                    if (rf_beat_valid) begin
                        bk_w_en   = 1'b1;
                        bk_w_set  = rfSetQ;
                        bk_w_way  = rfWayQ;
                        bk_w_off  = cntQ;
                        bk_w_data = rf_beat_data;
                        if (cntQ == LAST_OFF) begin
                            cntD   = '0;
                            stateD = DONE;
                        end else begin
                            cntD = cntQ + 1'b1;
                        end
                    end
                end
                DONE: begin
                    rf_done = 1'b1;
                    stateD  = IDLE;
                end
                default: stateD = IDLE;
            endcase
        end
    end

    // A read must not see a line that is half refilled, nor race a write to
    // the same set in this cycle. Reads to other sets go ahead.
    assign rdHazard = ((stateQ != IDLE) && (rd_set == rfSetQ)) ||
                      (bk_w_en && (bk_w_set == rd_set));
    assign rd_ready      = reset && rd_valid && !rdHazard;
    assign rd_resp_valid = rdRespQ;
    assign bk_r_set      = rd_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            rrLastQ <= 1'b0;
            rfSetQ  <= '0;
            rfWayQ  <= '0;
            rdRespQ <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the values from before this edge.
            stateQ  <= stateD;
            cntQ    <= cntD;
            rrLastQ <= rrLastD;
            rdRespQ <= rd_valid && rd_ready;
            if (latchRefill) begin
                rfSetQ <= rf_set;
                rfWayQ <= rf_way;
            end
        end
    end

endmodule

// File: tb/tb_data_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_bank_arbiter
//
// Directed scenarios plus a randomized run for data_bank_arbiter. Expected
// outputs come from a transaction-level model: a refill is tracked as "beats
// written so far" and a pending completion flag; the tie-break is tracked as
// "store wins the next tie".
// ---------------------------------------------------------------------------
module tb_data_bank_arbiter;

    localparam int SET_W      = 7;
    localparam int WAYS       = 8;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              st_valid = 1'b0;
    logic [SET_W-1:0]  st_set = '0;
    logic [WAYS-1:0]   st_way = '0;
    logic [OFF_W-1:0]  st_off = '0;
    logic [DATA_W-1:0] st_data = '0;
    logic              rf_start = 1'b0;
    logic [SET_W-1:0]  rf_set = '0;
    logic [WAYS-1:0]   rf_way = '0;
    logic              rf_beat_valid = 1'b0;
    logic [DATA_W-1:0] rf_beat_data = '0;
    logic              rd_valid = 1'b0;
    logic [SET_W-1:0]  rd_set = '0;

    logic              st_ready, rf_start_ready, rf_beat_ready, rf_done;
    logic              rd_ready, rd_resp_valid, bk_w_en;
    logic [SET_W-1:0]  bk_w_set, bk_r_set;
    logic [WAYS-1:0]   bk_w_way;
    logic [OFF_W-1:0]  bk_w_off;
    logic [DATA_W-1:0] bk_w_data;

    data_bank_arbiter #(
        .SET_W(SET_W), .WAYS(WAYS), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)
    ) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_set(st_set),
        .st_way(st_way), .st_off(st_off), .st_data(st_data),
        .rf_start(rf_start), .rf_start_ready(rf_start_ready),
        .rf_set(rf_set), .rf_way(rf_way),
        .rf_beat_valid(rf_beat_valid), .rf_beat_ready(rf_beat_ready),
        .rf_beat_data(rf_beat_data), .rf_done(rf_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_set(rd_set),
        .rd_resp_valid(rd_resp_valid),
        .bk_w_en(bk_w_en), .bk_w_set(bk_w_set), .bk_w_way(bk_w_way),
        .bk_w_off(bk_w_off), .bk_w_data(bk_w_data), .bk_r_set(bk_r_set)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic              stReady;
        logic              rfStartReady;
        logic              rfBeatReady;
        logic              rfDone;
        logic              rdReady;
        logic              rdRespValid;
        logic              wEn;
        logic [SET_W-1:0]  wSet;
        logic [WAYS-1:0]   wWay;
        logic [OFF_W-1:0]  wOff;
        logic [DATA_W-1:0] wData;
        logic [SET_W-1:0]  rSet;
    } outs_t;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit               mRefilling = 1'b0;
    bit               mDone      = 1'b0;
    bit               mStoreTurn = 1'b1;
    bit               mRespNext  = 1'b0;
    int               mBeats     = 0;
    logic [SET_W-1:0] mRefSet    = '0;
    logic [WAYS-1:0]  mRefWay    = '0;

    function automatic bit modelIdle();
        return !mRefilling && !mDone;
    endfunction

    function automatic outs_t predict();
        outs_t e;
        bit storeWins;
        e = '0;
        e.rSet = rd_set;
        if (!reset) return e;
        e.rdRespValid = mRespNext;
        if (modelIdle()) begin
            storeWins = st_valid && (!rf_start || mStoreTurn);
            if (storeWins) begin
                e.stReady = 1'b1;
                e.wEn     = 1'b1;
                e.wSet    = st_set;
                e.wWay    = st_way;
                e.wOff    = st_off;
                e.wData   = st_data;
            end
            e.rfStartReady = rf_start && !storeWins;
        end else if (mRefilling) begin
            e.rfBeatReady = 1'b1;
            if (rf_beat_valid) begin
                e.wEn   = 1'b1;
                e.wSet  = mRefSet;
                e.wWay  = mRefWay;
                e.wOff  = OFF_W'(mBeats);
                e.wData = rf_beat_data;
            end
        end else begin
            e.rfDone = 1'b1;
        end
        e.rdReady = rd_valid && !(!modelIdle() && rd_set == mRefSet) &&
                    !(e.wEn && e.wSet == rd_set);
        return e;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.stReady      = st_ready;
        o.rfStartReady = rf_start_ready;
        o.rfBeatReady  = rf_beat_ready;
        o.rfDone       = rf_done;
        o.rdReady      = rd_ready;
        o.rdRespValid  = rd_resp_valid;
        o.wEn          = bk_w_en;
        o.wSet         = bk_w_set;
        o.wWay         = bk_w_way;
        o.wOff         = bk_w_off;
        o.wData        = bk_w_data;
        o.rSet         = bk_r_set;
        return o;
    endfunction

    // Advance one clock: capture the pre-edge prediction, take the edge,
    // update the model, and return at the next falling edge.
    task automatic tick();
        outs_t e;
        e = predict();
        @(posedge clock);
        if (!reset) begin
            mRefilling = 1'b0; mDone = 1'b0; mStoreTurn = 1'b1;
            mRespNext = 1'b0; mBeats = 0; mRefSet = '0; mRefWay = '0;
        end else begin
            mRespNext = e.rdReady;
            if (modelIdle()) begin
                if (st_valid && rf_start) mStoreTurn = !mStoreTurn;
                if (e.rfStartReady) begin
                    mRefilling = 1'b1; mBeats = 0;
                    mRefSet = rf_set; mRefWay = rf_way;
                end
            end else if (mRefilling) begin
                if (rf_beat_valid) begin
                    mBeats++;
                    if (mBeats == LINE_WORDS) begin
                        mRefilling = 1'b0; mDone = 1'b1; mBeats = 0;
                    end
                end
            end else begin
                mDone = 1'b0;
            end
        end
        @(negedge clock);
    endtask

    task automatic clearInputs();
        st_valid = 1'b0; rf_start = 1'b0; rf_beat_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        outs_t e, o;
        @(negedge clock);
        st_valid = 1'b1; st_set = 7'd3; st_way = 8'h01; st_data = 32'h1234;
        rf_start = 1'b1; rf_beat_valid = 1'b1; rd_valid = 1'b1; rd_set = '0;
        #1;
        e = predict(); o = observe();
        total++;
        if (o !== e) begin bad++; $display("FAIL reset_model got=%h exp=%h", o, e); end
        total++;
        if ({st_ready, rf_start_ready, rf_beat_ready, rf_done, rd_ready, rd_resp_valid, bk_w_en} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0", {st_ready, rf_start_ready, rf_beat_ready, rf_done, rd_ready, rd_resp_valid, bk_w_en});
        end
        total++;
        if ({bk_w_set, bk_w_way, bk_w_off, bk_w_data} !== 49'd0) begin
            bad++;
            $display("FAIL reset_buses got=%h exp=0", {bk_w_set, bk_w_way, bk_w_off, bk_w_data});
        end
        tick();
        clearInputs();
        reset = 1'b1;
        #1;
        e = predict(); o = observe();
        total++;
        if (o !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", o, e); end
        tick();
    endtask

    task automatic test_store_alone();
        outs_t e, o;
        st_valid = 1'b1; st_set = 7'd5; st_way = 8'h04; st_off = 2'd2;
        st_data = 32'hDEADBEEF;
        #1;
        e = predict(); o = observe();
        total++;
        if (o !== e) begin bad++; $display("FAIL store_alone_model got=%h exp=%h", o, e); end
        total++;
        if ({st_ready, bk_w_en, bk_w_set, bk_w_way, bk_w_off, bk_w_data} !==
            {1'b1, 1'b1, 7'd5, 8'h04, 2'd2, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL store_alone_write got=%h exp=%h",
                     {st_ready, bk_w_en, bk_w_set, bk_w_way, bk_w_off, bk_w_data},
                     {1'b1, 1'b1, 7'd5, 8'h04, 2'd2, 32'hDEADBEEF});
        end
        tick();
        st_valid = 1'b0; rd_valid = 1'b1; rd_set = 7'd5;
        #1;
        total++;
        if (rd_ready !== 1'b1) begin bad++; $display("FAIL store_then_read_ready got=%b exp=1", rd_ready); end
        tick();
        rd_valid = 1'b0;
        #1;
        total++;
        if (rd_resp_valid !== 1'b1) begin bad++; $display("FAIL store_then_read_resp got=%b exp=1", rd_resp_valid); end
        tick();
    endtask

    task automatic test_refill_gaps();
        outs_t e, o;
        logic [DATA_W-1:0] beatData;
        clearInputs();
        rf_start = 1'b1; rf_set = 7'd9; rf_way = 8'h80;
        #1;
        total++;
        if ({rf_start_ready, bk_w_en} !== 2'b10) begin
            bad++; $display("FAIL refill_accept got=%b exp=10", {rf_start_ready, bk_w_en});
        end
        tick();
        rf_start = 1'b0; rf_set = 7'($urandom);   // must be ignored after acceptance
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (i == 2) begin
                rf_beat_valid = 1'b0;
                #1;
                e = predict(); o = observe();
                total++;
                if (o !== e || bk_w_en !== 1'b0) begin
                    bad++; $display("FAIL refill_gap got=%h exp=%h", o, e);
                end
                tick();
            end
            beatData = $urandom;
            rf_beat_valid = 1'b1; rf_beat_data = beatData;
            #1;
            total++;
            if ({bk_w_en, bk_w_set, bk_w_way, bk_w_off, bk_w_data} !==
                {1'b1, 7'd9, 8'h80, 2'(i), beatData}) begin
                bad++;
                $display("FAIL refill_beat%0d got=%h exp=%h", i,
                         {bk_w_en, bk_w_set, bk_w_way, bk_w_off, bk_w_data},
                         {1'b1, 7'd9, 8'h80, 2'(i), beatData});
            end
            tick();
        end
        rf_beat_valid = 1'b0;
        #1;
        total++;
        if (rf_done !== 1'b1) begin bad++; $display("FAIL refill_done_pulse got=%b exp=1", rf_done); end
        tick();
        #1;
        total++;
        if ({rf_done, rf_beat_ready} !== 2'b00) begin
            bad++; $display("FAIL refill_back_idle got=%b exp=00", {rf_done, rf_beat_ready});
        end
        tick();
    endtask

    task automatic test_read_hazard();
        outs_t e, o;
        bit finished;
        clearInputs();
        rf_start = 1'b1; rf_set = 7'd9; rf_way = 8'h01 << ($urandom % WAYS);
        tick();
        rf_start = 1'b0;
        finished = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            rd_valid = 1'b1;
            rd_set = c[0] ? 7'd10 : 7'd9;
            rf_beat_valid = (c == 0) ? 1'b0 : 1'($urandom);
            rf_beat_data = $urandom;
            #1;
            e = predict(); o = observe();
            total++;
            if (o !== e) begin bad++; $display("FAIL hazard_model c=%0d got=%h exp=%h", c, o, e); end
            total++;
            if (rd_ready !== (rd_set == 7'd10)) begin
                bad++; $display("FAIL hazard_rd_ready set=%0d got=%b exp=%b", rd_set, rd_ready, rd_set == 7'd10);
            end
            tick();
            finished = modelIdle();
        end
        total++;
        if (!finished) begin bad++; $display("FAIL hazard_timeout got=busy exp=idle"); end
        rf_beat_valid = 1'b0; rd_set = 7'd9;
        #1;
        total++;
        if (rd_ready !== 1'b1) begin bad++; $display("FAIL hazard_cleared got=%b exp=1", rd_ready); end
        tick();
        rd_valid = 1'b0;
        #1;
        total++;
        if (rd_resp_valid !== 1'b1) begin bad++; $display("FAIL hazard_cleared_resp got=%b exp=1", rd_resp_valid); end
        tick();
    endtask

    // Ends with a refill in progress and the store still held, which the
    // store-during-refill scenario picks up.
    task automatic test_round_robin();
        outs_t e, o;
        clearInputs();
        st_valid = 1'b1; st_set = 7'd40; st_way = 8'h02; st_off = 2'd1; st_data = $urandom;
        rf_start = 1'b1; rf_set = 7'd20; rf_way = 8'h01;
        #1;
        total++;
        if ({st_ready, rf_start_ready} !== 2'b10) begin
            bad++; $display("FAIL rr_first_tie got=%b exp=10", {st_ready, rf_start_ready});
        end
        tick();
        st_valid = 1'b0;
        #1;
        total++;
        if (rf_start_ready !== 1'b1) begin bad++; $display("FAIL rr_refill_next got=%b exp=1", rf_start_ready); end
        tick();
        rf_start = 1'b0;
        for (int i = 0; i < LINE_WORDS + 1; i++) begin
            rf_beat_valid = (i < LINE_WORDS); rf_beat_data = $urandom;
            #1;
            e = predict(); o = observe();
            total++;
            if (o !== e) begin bad++; $display("FAIL rr_refill_seq i=%0d got=%h exp=%h", i, o, e); end
            tick();
        end
        rf_beat_valid = 1'b0;
        st_valid = 1'b1; rf_start = 1'b1; rf_set = 7'd21; rf_way = 8'h10;
        #1;
        total++;
        if ({st_ready, rf_start_ready} !== 2'b01) begin
            bad++; $display("FAIL rr_second_tie got=%b exp=01", {st_ready, rf_start_ready});
        end
        tick();
        rf_start = 1'b0;
    endtask

    task automatic test_store_during_refill();
        outs_t e, o;
        bit accepted;
        accepted = 1'b0;
        for (int c = 0; c < 30 && !accepted; c++) begin
            rf_beat_valid = 1'($urandom); rf_beat_data = $urandom;
            #1;
            e = predict(); o = observe();
            total++;
            if (o !== e) begin bad++; $display("FAIL st_in_refill_model c=%0d got=%h exp=%h", c, o, e); end
            total++;
            if (st_ready !== modelIdle()) begin
                bad++; $display("FAIL st_in_refill_ready c=%0d got=%b exp=%b", c, st_ready, modelIdle());
            end
            accepted = modelIdle();
            tick();
        end
        total++;
        if (!accepted) begin bad++; $display("FAIL st_in_refill_timeout got=held exp=accepted"); end
        clearInputs();
        tick();
    endtask

    task automatic test_reset_mid_refill();
        outs_t e, o;
        clearInputs();
        rf_start = 1'b1; rf_set = 7'd33; rf_way = 8'h02;
        tick();
        rf_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rf_beat_valid = 1'b1; rf_beat_data = $urandom;
            tick();
        end
        reset = 1'b0; st_valid = 1'b1; rd_valid = 1'b1; rd_set = 7'd1;
        #1;
        total++;
        if ({st_ready, rf_start_ready, rf_beat_ready, rf_done, rd_ready, rd_resp_valid, bk_w_en} !== 7'b0) begin
            bad++;
            $display("FAIL midreset_flags got=%b exp=0", {st_ready, rf_start_ready, rf_beat_ready, rf_done, rd_ready, rd_resp_valid, bk_w_en});
        end
        tick();
        clearInputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({rf_done, rf_beat_ready} !== 2'b00) begin
                bad++; $display("FAIL midreset_no_done i=%0d got=%b exp=00", i, {rf_done, rf_beat_ready});
            end
            tick();
        end
        rf_start = 1'b1; rf_set = 7'd34; rf_way = 8'h08;
        tick();
        rf_start = 1'b0;
        for (int i = 0; i < LINE_WORDS + 1; i++) begin
            rf_beat_valid = (i < LINE_WORDS); rf_beat_data = $urandom;
            #1;
            e = predict(); o = observe();
            total++;
            if (o !== e) begin bad++; $display("FAIL midreset_restart i=%0d got=%h exp=%h", i, o, e); end
            if (i == 0) begin
                total++;
                if ({bk_w_en, bk_w_set, bk_w_off} !== {1'b1, 7'd34, 2'd0}) begin
                    bad++; $display("FAIL midreset_first_off got=%h exp=%h", {bk_w_en, bk_w_set, bk_w_off}, {1'b1, 7'd34, 2'd0});
                end
            end
            tick();
        end
        clearInputs();
        tick();
    endtask

    task automatic test_random();
        outs_t e, o;
        for (int c = 0; c < 400; c++) begin
            st_valid = ($urandom % 2) == 0;
            st_set = 7'($urandom % 4); st_way = 8'h01 << ($urandom % WAYS);
            st_off = 2'($urandom); st_data = $urandom;
            rf_start = ($urandom % 4) == 0;
            rf_set = 7'($urandom % 4); rf_way = 8'h01 << ($urandom % WAYS);
            rf_beat_valid = 1'($urandom); rf_beat_data = $urandom;
            rd_valid = 1'($urandom); rd_set = 7'($urandom % 4);
            #1;
            e = predict(); o = observe();
            total++;
            if (o !== e) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", c, o, e); end
            tick();
        end
        clearInputs();
        rf_beat_valid = 1'b1;
        for (int c = 0; c < 10 && !modelIdle(); c++) tick();
        rf_beat_valid = 1'b0;
        #1;
        e = predict(); o = observe();
        total++;
        if (o !== e) begin bad++; $display("FAIL random_drain got=%h exp=%h", o, e); end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_alone();
        test_refill_gaps();
        test_read_hazard();
        test_round_robin();
        test_store_during_refill();
        test_reset_mid_refill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
